// File: rtl/fixed_to_float.sv
// rtl/fixed_to_float.sv - signed fixed-point to 16-bit float {sign, exp+16, mant}, 3-stage valid/ready pipeline; FTF_ROUND_NEAREST_EN selects round-to-nearest-even
module fixed_to_float #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf
);

  // Exponent is p - FRAC + 16; the constant part is folded here.
  localparam logic signed [7:0] EXP_OFS = 8'(16 - FRAC);
  // Left-aligned magnitude padded below so mant, guard and sticky always exist.
  localparam int EW = WIDTH + 11;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_zero_q, s1_zero_d;
  logic [WIDTH-1:0] s1_abs_q, s1_abs_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q, s2_sign_d;
  logic             s2_zero_q, s2_zero_d;
  logic [5:0]       s2_p_q, s2_p_d;
  logic [9:0]       s2_mant_q, s2_mant_d;
  logic             s2_round_q, s2_round_d;

  logic             s3_valid_q, s3_valid_d;
  logic [15:0]      s3_data_q, s3_data_d;
  logic             s3_zero_q, s3_zero_d;
  logic             s3_ovf_q, s3_ovf_d;
  logic             s3_unf_q, s3_unf_d;

  logic             s3_ready, s2_moves, s1_moves;
  logic [5:0]       shamt;
  logic [WIDTH-1:0] norm;
  logic [EW-1:0]    ext;
  logic signed [7:0] e;
  logic [10:0]      m11;

  // Stage handshakes: a stage may load when empty or when it empties this cycle.
  always_comb begin
    s3_ready = !s3_valid_q || out_ready;
    s2_moves = s2_valid_q && s3_ready;
    s1_moves = s1_valid_q && (!s2_valid_q || s2_moves);
    in_ready = !s1_valid_q || s1_moves;
  end

  // S1: capture sign, magnitude and zero flag of the accepted sample.
  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_abs_d   = s1_abs_q;
    if (in_valid && in_ready) begin
      s1_sign_d = in_data[WIDTH-1];
      s1_abs_d  = in_data[WIDTH-1] ? -in_data : in_data;
      s1_zero_d = (in_data == '0);
    end
  end

  // S2: find the leading one, normalise, and precompute the rounding increment.
  always_comb begin
    s2_p_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_abs_q[i]) s2_p_d = 6'(i);
    end
    shamt     = 6'(WIDTH - 1) - s2_p_d;
    norm      = s1_abs_q << shamt;
    ext       = {norm, 11'b0};
    s2_mant_d = 10'(ext >> (WIDTH + 1));
`ifdef FTF_ROUND_NEAREST_EN
    s2_round_d = ext[WIDTH] && ((|ext[WIDTH-1:0]) || s2_mant_d[0]);
`else
    s2_round_d = 1'b0;
`endif
    s2_valid_d = s1_moves || (s2_valid_q && !s2_moves);
    s2_sign_d  = s1_sign_q;
    s2_zero_d  = s1_zero_q;
    if (!s1_moves) begin
      s2_p_d     = s2_p_q;
      s2_mant_d  = s2_mant_q;
      s2_round_d = s2_round_q;
      s2_sign_d  = s2_sign_q;
      s2_zero_d  = s2_zero_q;
    end
  end

  // S3: apply rounding carry, then classify into zero / saturate / flush / normal.
  always_comb begin
    e   = $signed({2'b00, s2_p_q}) + EXP_OFS;
    m11 = {1'b0, s2_mant_q} + {10'b0, s2_round_q};
    if (m11[10]) begin
      m11 = 11'd512;
      e   = e + 8'sd1;
    end
    s3_valid_d = s3_ready ? s2_valid_q : s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_zero_d  = s3_zero_q;
    s3_ovf_d   = s3_ovf_q;
    s3_unf_d   = s3_unf_q;
    if (s2_moves) begin
      s3_zero_d = 1'b0;
      s3_ovf_d  = 1'b0;
      s3_unf_d  = 1'b0;
      if (s2_zero_q) begin
        s3_data_d = 16'h0000;
        s3_zero_d = 1'b1;
      end else if (e > 8'sd31) begin
        s3_data_d = {s2_sign_q, 5'd31, 10'h3FF};
        s3_ovf_d  = 1'b1;
      end else if (e < 8'sd0) begin
        s3_data_d = 16'h0000;
        s3_zero_d = 1'b1;
        s3_unf_d  = 1'b1;
      end else begin
        s3_data_d = {s2_sign_q, e[4:0], m11[9:0]};
      end
    end
  end

  // Pipeline registers; reset empties every stage and clears the output word.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_abs_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_p_q     <= '0;
      s2_mant_q  <= '0;
      s2_round_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= 16'h0000;
      s3_zero_q  <= 1'b0;
      s3_ovf_q   <= 1'b0;
      s3_unf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_abs_q   <= s1_abs_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_p_q     <= s2_p_d;
      s2_mant_q  <= s2_mant_d;
      s2_round_q <= s2_round_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_zero_q  <= s3_zero_d;
      s3_ovf_q   <= s3_ovf_d;
      s3_unf_q   <= s3_unf_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_zero  = s3_zero_q;
  assign out_ovf   = s3_ovf_q;
  assign out_unf   = s3_unf_q;

endmodule
